// File: rtl/sha256_padder_if.sv
// Stream-in / core-out bundle for sha256_padder.
// The slave side is the padder; the master side is the environment (stream source and Sha256 core).
interface sha256_padder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [1:0]  in_bytes;
  logic        core_rst_n;
  logic        calcu_en;
  logic [31:0] word_out;
  logic        calcu_rdy;
  logic        msg_done;

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, calcu_rdy,
    output in_ready, core_rst_n, calcu_en, word_out, msg_done
  );

  modport master (
    output in_valid, in_data, in_last, in_bytes, calcu_rdy,
    input  in_ready, core_rst_n, calcu_en, word_out, msg_done
  );
endinterface

// File: rtl/sha256_padder.sv
// FIPS 180-4 padder feeding a Sha256 core 16 words per block.
// It also pulses the core reset at message start so each digest begins from the initial constants.
module sha256_padder (
  input  logic            clk,
  input  logic            rst,
  sha256_padder_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_CRST, S_FILL, S_WAIT, S_SEND, S_DONE} state_t;

  state_t      state, state_d;
  logic [31:0] blk [16];
  logic [3:0]  widx, k;
  logic [63:0] len, len_new;
  logic        pad_placed, len_pending, final_blk, first;

  logic        in_ready_q, calcu_en_q, core_rst_n_q, msg_done_q;
  logic [31:0] word_out_q;
  logic        in_ready_d, calcu_en_d, core_rst_n_d, msg_done_d;
  logic [31:0] word_out_d;

  logic        accept, send_last, build_extra;
  logic [2:0]  nbytes;
  logic [4:0]  pad_idx;
  logic [31:0] last_word;

  assign bus.in_ready   = in_ready_q;
  assign bus.calcu_en   = calcu_en_q;
  assign bus.word_out   = word_out_q;
  assign bus.core_rst_n = core_rst_n_q;
  assign bus.msg_done   = msg_done_q;

  always_comb begin
    accept      = in_ready_q & bus.in_valid;
    nbytes      = (bus.in_bytes == 2'd0) ? 3'd4 : {1'b0, bus.in_bytes};
    len_new     = len + (bus.in_last ? {58'd0, nbytes, 3'd0} : 64'd32);
    // pad_idx == 16 means the 0x80 spills into word 0 of an extra block
    pad_idx     = {1'b0, widx} + ((nbytes == 3'd4) ? 5'd1 : 5'd0);
    send_last   = (state == S_SEND) && (k == 4'd15);
    build_extra = send_last && !final_blk && len_pending;
    case (nbytes)
      3'd1:    last_word = {bus.in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {bus.in_data[31:16], 16'h8000};
      3'd3:    last_word = {bus.in_data[31:8],  8'h80};
      default: last_word = bus.in_data;
    endcase
  end

  always_comb begin
    state_d    = state;
    calcu_en_d = 1'b0;
    word_out_d = '0;
    msg_done_d = msg_done_q;
    case (state)
      S_IDLE: if (bus.in_valid) begin
        state_d    = S_CRST;
        msg_done_d = 1'b0;
      end
      S_CRST: state_d = S_FILL;
      S_FILL: if (accept && (bus.in_last || widx == 4'd15)) state_d = S_WAIT;
      S_WAIT: if (first || bus.calcu_rdy) begin
        state_d    = S_SEND;
        calcu_en_d = 1'b1;
        word_out_d = blk[0];
      end
      S_SEND: begin
        if (k == 4'd15)
          state_d = final_blk ? S_DONE : (len_pending ? S_WAIT : S_FILL);
        else
          word_out_d = blk[k + 4'd1];
      end
      S_DONE: if (bus.calcu_rdy) begin
        state_d    = S_IDLE;
        msg_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d   = (state_d == S_FILL);
    core_rst_n_d = (state_d != S_CRST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      in_ready_q   <= 1'b0;
      calcu_en_q   <= 1'b0;
      word_out_q   <= '0;
      core_rst_n_q <= 1'b0;
      msg_done_q   <= 1'b0;
    end else begin
      state        <= state_d;
      in_ready_q   <= in_ready_d;
      calcu_en_q   <= calcu_en_d;
      word_out_q   <= word_out_d;
      core_rst_n_q <= core_rst_n_d;
      msg_done_q   <= msg_done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx        <= '0;
      k           <= '0;
      len         <= '0;
      pad_placed  <= 1'b0;
      len_pending <= 1'b0;
      final_blk   <= 1'b0;
      first       <= 1'b0;
    end else begin
      case (state)
        S_CRST: begin
          widx        <= '0;
          len         <= '0;
          pad_placed  <= 1'b0;
          len_pending <= 1'b0;
          final_blk   <= 1'b0;
          first       <= 1'b1;
        end
        S_FILL: if (accept) begin
          widx <= widx + 4'd1;
          len  <= len_new;
          if (bus.in_last) begin
            if (pad_idx <= 5'd13) begin
              final_blk <= 1'b1;
            end else begin
              len_pending <= 1'b1;
              pad_placed  <= (pad_idx <= 5'd15);
            end
          end
        end
        S_WAIT: if (first || bus.calcu_rdy) begin
          first <= 1'b0;
          k     <= '0;
        end
        S_SEND: begin
          k <= k + 4'd1;
          if (build_extra) begin
            len_pending <= 1'b0;
            final_blk   <= 1'b1;
          end else if (send_last && !final_blk) begin
            widx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Padding is written in full on the last-word cycle, so every block is complete before WAIT.
  always_ff @(posedge clk) begin
    if (state == S_FILL && accept) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (4'(i) == widx)
          blk[i] <= bus.in_last ? last_word : bus.in_data;
        else if (bus.in_last && 4'(i) > widx)
          blk[i] <= (5'(i) == pad_idx) ? 32'h8000_0000 : '0;
      end
      if (bus.in_last && pad_idx <= 5'd13) begin
        blk[14] <= len_new[63:32];
        blk[15] <= len_new[31:0];
      end
    end else if (build_extra) begin
      blk[0] <= pad_placed ? '0 : 32'h8000_0000;
      for (int unsigned i = 1; i < 14; i++) blk[i] <= '0;
      blk[14] <= len[63:32];
      blk[15] <= len[31:0];
    end
  end

endmodule
